// File: rtl/image_stream_reader.sv
// Streams NUM_PIXELS pixels from image memory onto a valid/ready port; first pixel 3 cycles after start.
// Reads are credit-limited to a 2-entry skid buffer, so sink backpressure stalls issue without loss.
module image_stream_reader #(
    parameter int                ADDR_W     = 22,
    parameter int                PIX_W      = 8,
    parameter logic [ADDR_W-1:0] IMG_BASE   = '0,
    parameter int                NUM_PIXELS = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_adr,
    input  logic [PIX_W-1:0]  img_rd_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    localparam int               CNT_W    = $clog2(NUM_PIXELS + 1);
    localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_PIXELS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   issued, accepted;
    logic               inflight;
    logic [PIX_W-1:0]   head_q, tail_q;
    logic [1:0]         buf_cnt;
    logic               push, pop;
    logic [2:0]         occ_nxt;
    logic               last_accept;

    assign push        = inflight;
    assign pop         = pix_valid & pix_ready;
    assign last_accept = pop && (accepted == LAST_IDX);

    // Occupancy after this cycle's pop, counting the read still in flight;
    // using the post-pop value is what keeps the stream bubble-free.
    assign occ_nxt   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign img_rd_en = (state == ST_RUN) && (issued < NUM_C) && (occ_nxt < 3'd2);
    assign img_adr   = IMG_BASE + ADDR_W'(issued);

    assign pix_valid = (buf_cnt != 2'd0);
    assign pix_data  = head_q;
    assign pix_last  = pix_valid && (accepted == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_accept) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Counters are cleared on the way out of a frame so IDLE always presents IMG_BASE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= img_rd_en;
            if (state == ST_DONE) begin
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (img_rd_en) issued   <= issued + CNT_W'(1);
                if (pop)       accepted <= accepted + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            buf_cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) head_q <= img_rd_data;
                    else                 tail_q <= img_rd_data;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        head_q <= img_rd_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= img_rd_data;
                    end
                end
                default: begin
                    buf_cnt <= buf_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_stream_reader.sv
// Four reader instances (N=4, N=1, N=4 at a wrapping base, N=8) against a 1-cycle image memory.
// Memory content is a fixed function of address so every pixel is predictable.
module tb_image_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start = '0;
    logic [3:0] ready = '0;
    logic [3:0] rd_en, valid, last, busy, done;
    logic [21:0] adr [4];
    logic [7:0]  rd_data [4];
    logic [7:0]  pix_data [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input logic [21:0] a);
        return 8'hA0 + a[7:0];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        image_stream_reader #(
            .ADDR_W    (22),
            .PIX_W     (8),
            .IMG_BASE  ((g == 2) ? 22'h3FFFFE : 22'h0),
            .NUM_PIXELS((g == 1) ? 1 : ((g == 3) ? 8 : 4))
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n),
            .start      (start[g]),
            .img_rd_en  (rd_en[g]),
            .img_adr    (adr[g]),
            .img_rd_data(rd_data[g]),
            .pix_data   (pix_data[g]),
            .pix_valid  (valid[g]),
            .pix_ready  (ready[g]),
            .pix_last   (last[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i]) rd_data[i] <= pix_of(adr[i]);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input int g, input string tag);
        chk({tag, "_rd_en"}, int'(rd_en[g]), 0);
        chk({tag, "_adr"},   int'(adr[g]), (g == 2) ? 32'h3FFFFE : 0);
        chk({tag, "_valid"}, int'(valid[g]), 0);
        chk({tag, "_data"},  int'(pix_data[g]), 0);
        chk({tag, "_last"},  int'(last[g]), 0);
        chk({tag, "_busy"},  int'(busy[g]), 0);
        chk({tag, "_done"},  int'(done[g]), 0);
    endtask

    // Runs one frame on instance g. mode 0: ready=1; 1: ready 1,0,0 repeating; 2: ready=0 for 10 cycles.
    task automatic stream(input int g, input int mode, input int nexp, input logic [21:0] base,
                          input int exp_done_c, input bit poke);
        int niss = 0;
        int nacc = 0;
        bit held = 1'b0;
        bit seen_done = 1'b0;
        logic [7:0] hd = '0;
        logic hl = 1'b0;
        logic [21:0] ea;
        start[g] = 1'b1;
        ready[g] = (mode == 0);
        @(negedge clk);
        next_cycle();
        start[g] = 1'b0;
        for (int c = 1; c < 400 && !seen_done; c++) begin
            ready[g] = (mode == 0) ? 1'b1 : ((mode == 1) ? (c % 3 == 1) : (c > 10));
            start[g] = poke && (c == 4 || c == exp_done_c);
            @(negedge clk);
            if (held) begin
                chk($sformatf("g%0d_hold_valid_c%0d", g, c), int'(valid[g]), 1);
                chk($sformatf("g%0d_hold_data_c%0d", g, c), int'(pix_data[g]), int'(hd));
                chk($sformatf("g%0d_hold_last_c%0d", g, c), int'(last[g]), int'(hl));
            end
            if (rd_en[g]) begin
                ea = base + 22'(niss);
                chk($sformatf("g%0d_adr_%0d", g, niss), int'(adr[g]), int'(ea));
                niss++;
            end
            if (valid[g] && ready[g]) begin
                ea = base + 22'(nacc);
                chk($sformatf("g%0d_pix_%0d", g, nacc), int'(pix_data[g]), int'(pix_of(ea)));
                chk($sformatf("g%0d_last_%0d", g, nacc), int'(last[g]), int'(nacc == nexp - 1));
                nacc++;
            end
            held = valid[g] && !ready[g];
            hd = pix_data[g];
            hl = last[g];
            chk($sformatf("g%0d_outstanding_c%0d", g, c), int'((niss - nacc) <= 2), 1);
            if (mode == 2 && c == 10) begin
                chk($sformatf("g%0d_stall_reads", g), niss, 2);
                chk($sformatf("g%0d_stall_valid", g), int'(valid[g]), 1);
                chk($sformatf("g%0d_stall_data", g), int'(pix_data[g]), int'(pix_of(base)));
            end
            if (done[g]) begin
                seen_done = 1'b1;
                if (exp_done_c != 0) chk($sformatf("g%0d_done_cycle", g), c, exp_done_c);
            end
            next_cycle();
        end
        start[g] = 1'b0;
        chk($sformatf("g%0d_seen_done", g), int'(seen_done), 1);
        chk($sformatf("g%0d_accepted", g), nacc, nexp);
        chk($sformatf("g%0d_issued", g), niss, nexp);
        @(negedge clk);
        chk($sformatf("g%0d_busy_after", g), int'(busy[g]), 0);
        chk($sformatf("g%0d_done_after", g), int'(done[g]), 0);
        next_cycle();
        @(negedge clk);
        chk($sformatf("g%0d_idle_busy", g), int'(busy[g]), 0);
        chk($sformatf("g%0d_idle_rd_en", g), int'(rd_en[g]), 0);
        next_cycle();
    endtask

    typedef struct packed {
        logic        start;
        logic        ready;
        logic        rd_en;
        logic [21:0] adr;
        logic        vld;
        logic [7:0]  dat;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic e, input logic [21:0] a,
                                input logic v, input logic [7:0] d, input logic l,
                                input logic b, input logic dn);
        vec_t t;
        t.start = s; t.ready = r; t.rd_en = e; t.adr = a; t.vld = v;
        t.dat = d; t.last = l; t.busy = b; t.done = dn;
        return t;
    endfunction

    initial begin
        vec_t tbl [9];
        int nacc;
        tbl[0] = mk(1'b1, 1'b1, 1'b0, 22'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 1'b1, 1'b1, 22'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[2] = mk(1'b0, 1'b1, 1'b1, 22'h1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[3] = mk(1'b0, 1'b1, 1'b1, 22'h2, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0);
        tbl[4] = mk(1'b0, 1'b1, 1'b1, 22'h3, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
        tbl[5] = mk(1'b0, 1'b1, 1'b0, 22'h0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
        tbl[6] = mk(1'b0, 1'b1, 1'b0, 22'h0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0);
        tbl[7] = mk(1'b0, 1'b1, 1'b0, 22'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        tbl[8] = mk(1'b0, 1'b1, 1'b0, 22'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        #3;
        for (int g = 0; g < 4; g++) chk_reset_outputs(g, $sformatf("rst%0d", g));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Nominal 4-pixel frame, cycle by cycle.
        for (int k = 0; k < 9; k++) begin
            start[0] = tbl[k].start;
            ready[0] = tbl[k].ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_rd_en", k), int'(rd_en[0]), int'(tbl[k].rd_en));
            if (tbl[k].rd_en) chk($sformatf("tbl%0d_adr", k), int'(adr[0]), int'(tbl[k].adr));
            chk($sformatf("tbl%0d_valid", k), int'(valid[0]), int'(tbl[k].vld));
            if (tbl[k].vld) chk($sformatf("tbl%0d_data", k), int'(pix_data[0]), int'(tbl[k].dat));
            chk($sformatf("tbl%0d_last", k), int'(last[0]), int'(tbl[k].last));
            chk($sformatf("tbl%0d_busy", k), int'(busy[0]), int'(tbl[k].busy));
            chk($sformatf("tbl%0d_done", k), int'(done[0]), int'(tbl[k].done));
            next_cycle();
        end
        start[0] = 1'b0;

        stream(0, 1, 4, 22'h0, 0, 1'b0);
        stream(0, 2, 4, 22'h0, 15, 1'b0);
        stream(0, 0, 4, 22'h0, 7, 1'b1);
        stream(1, 0, 1, 22'h0, 4, 1'b1);
        stream(2, 0, 4, 22'h3FFFFE, 7, 1'b0);

        // Reset in the middle of an 8-pixel frame after 5 pixels.
        nacc = 0;
        start[3] = 1'b1;
        ready[3] = 1'b1;
        @(negedge clk);
        next_cycle();
        start[3] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (valid[3] && ready[3]) nacc++;
            if (c < 7) next_cycle();
        end
        chk("midrst_accepted", nacc, 5);
        chk("midrst_valid_before", int'(valid[3]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs(3, "midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("postrst_valid_c%0d", c), int'(valid[3]), 0);
            chk($sformatf("postrst_busy_c%0d", c), int'(busy[3]), 0);
        end
        next_cycle();
        stream(3, 0, 8, 22'h0, 11, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
